databus_rr_arbiter: RTL
=======================

Name: databus_rr_arbiter

Overview:
- Shares one simple-AXI master (separate read and write channels) between N_SLAVES Versat IO databus requesters.
- Replaces fixed-priority merging with independent round-robin arbitration per channel. A grant is locked for a whole burst.
- Sits between versat_instance m_databus_* and the simple-to-AXI bridge.

Parameters:
- N_SLAVES, 2, number of requesters (>=1).
- ADDR_W, 32, databus address width.
- DATA_W, 32, databus data width (multiple of 8).
- ID_W, max(1,$clog2(N_SLAVES)), derived localparam; grant index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  N_SLAVES  per-requester valid.
- s_ready  out  N_SLAVES  per-requester ready.
- s_last  out  N_SLAVES  per-requester last-beat indication.
- s_addr  in  N_SLAVES*ADDR_W  packed addresses, slave g at [g*ADDR_W +: ADDR_W].
- s_wdata  in  N_SLAVES*DATA_W  packed write data.
- s_wstrb  in  N_SLAVES*DATA_W/8  packed strobes; nonzero means write request, zero means read request.
- s_len  in  N_SLAVES*8  packed burst length (beats-1).
- s_rdata  out  DATA_W  broadcast read data.
- m_wvalid/m_wready/m_wlast  out/in/in  1  write channel handshake and last.
- m_waddr, m_wdata, m_wstrb, m_wlen  out  ADDR_W, DATA_W, DATA_W/8, 8  write request fields.
- m_rvalid/m_rready/m_rlast  out/in/in  1  read channel handshake and last.
- m_raddr, m_rlen  out  ADDR_W, 8  read request fields.
- m_rdata  in  DATA_W  read data.
- w_busy, r_busy  out  1  channel granted.
- w_gnt, r_gnt  out  ID_W  granted requester index.

Behaviour:
- Reset values:
  - w_busy=r_busy=0; w_gnt=r_gnt=0.
  - Round-robin pointers w_ptr=r_ptr=N_SLAVES-1, so slave 0 wins first.
  - All m_* outputs 0; s_ready=s_last=0.
- Per-channel FSM (write and read identical, fully independent): IDLE, BURST.
- IDLE:
  - Candidates are s_valid[i] with matching class: write if |wstrb_i, read otherwise.
  - Winner is the first candidate scanning i = ptr+1, ptr+2, ... modulo N_SLAVES.
  - On a winner: register gnt=winner, ptr=winner, go to BURST.
  - Grant latency is 1 cycle: m_*valid can first assert the cycle after the request.
- BURST:
  - m_wvalid = s_valid[gnt] & |wstrb[gnt]; m_rvalid = s_valid[gnt] & ~|wstrb[gnt].
  - m_* fields are muxed from slave gnt; non-granted channel outputs are 0.
  - s_ready[gnt] = m_*ready and s_last[gnt] = m_*last, OR-combined across the two channels.
  - Requester valid may drop between beats; the grant is held.
  - On m_*valid & m_*ready & m_*last, return to IDLE.
  - One idle bubble follows each burst; re-arbitration happens in IDLE the next cycle.
- Simultaneous events:
  - A slave may hold a read grant and a write grant at once only if its class changes.
  - The class seen by a granted channel is evaluated every cycle, so a class change stalls that channel (valid=0) rather than corrupting it.
- s_rdata = m_rdata, unconditionally combinational.
- Fairness: with all N requesters continuously requesting one channel, each gets exactly one burst per N bursts.
- Reset mid-burst: immediate return to IDLE. The pointer reset means the downstream bridge must also be reset; it shares rst.
- N_SLAVES=1: arbitration degenerates to the request itself; gnt is always 0.
- Purely combinational paths: m_*valid, m_*ready→s_ready, m_*last→s_last. No registered data path.

Decomposition:
- Shared package/header holds:
  - the class-decode helper (strobe-OR → is_write);
  - the databus length width constant (8);
  - the FSM state encodings IDLE=1'b0, BURST=1'b1.
- One sub-module, rr_grant (N, req vector, ptr → winner index, any), instantiated twice, once per channel.

Test Plan:
- Reset, then slave0 read (len=3), slave1 idle; bridge returns 4 beats with rlast on beat 4:
  - r_gnt=0;
  - m_rvalid asserts the cycle after the request;
  - s_ready[0] pulses 4 times;
  - s_last[0] on beat 4;
  - r_busy drops the next cycle.
- Slaves 0 and 1 both issue continuous reads (len=0):
  - grant sequence is 0,1,0,1;
  - each grant is separated by one idle cycle.
- Slave0 write (wstrb=4'hF, len=1) concurrent with slave1 read (len=1):
  - both channels busy in the same cycle;
  - w_gnt=0, r_gnt=1;
  - no cross-talk on s_ready or s_last.
- Granted slave drops s_valid for 3 cycles mid-burst (len=2):
  - grant held, m_rvalid=0 during the gap;
  - another requesting slave is not granted until rlast completes.
- Assert rst during beat 2 of a 4-beat write:
  - all outputs 0 immediately (asynchronous);
  - after release, slave0 is granted first.
- N_SLAVES=3, all requesting writes continuously:
  - grant order 0,1,2,0;
  - each slave's addr/wdata appears on m_waddr/m_wdata only during its own grant.

Source files
------------

// File: rtl/databus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : databus_rr_arbiter_pkg
// Description : Shared definitions for the databus round-robin arbiter.
//               Holds the databus burst-length width, the per-channel FSM
//               state encoding and the request class decode helper
//               (nonzero strobe = write, zero strobe = read).
// Revision    : 1.0 - initial release
// ============================================================================
package databus_rr_arbiter_pkg;

   // Width of the databus burst length field (beats-1).
   localparam int LEN_W = 8;

   // Widest strobe vector the class decode accepts (DATA_W up to 1024).
   localparam int STRB_MAX_W = 128;

   // Per-channel arbitration state.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } ch_state_t;

   // A request is a write when any byte strobe is set, a read otherwise.
   // Callers zero-extend their strobe vector to STRB_MAX_W bits.
   function automatic logic is_write(input logic [STRB_MAX_W-1:0] strb);
      return |strb;
   endfunction

endpackage : databus_rr_arbiter_pkg
`default_nettype wire

// File: rtl/databus_rr_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : databus_rr_arbiter_rr_grant
// Description : Combinational round-robin winner selection. Scans the
//               request vector starting one position after the pointer,
//               wrapping modulo N, and returns the first requester found.
// Ports       : i_req  [N-1:0]    request vector
//               i_ptr  [ID_W-1:0] index of the previous winner (< N)
//               o_idx  [ID_W-1:0] winning index (0 when no request)
//               o_any             at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module databus_rr_arbiter_rr_grant #(
   parameter int N    = 2,
   parameter int ID_W = 1
) (
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [ID_W-1:0] o_idx,
   output logic            o_any
);

   int w_dist;
   int w_best;

   // Each requester's distance from the pointer in scan order: the
   // requester right after the pointer has distance 0, the pointer itself
   // has distance N-1. The smallest distance among requesters wins.
   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_dist = 0;
      w_best = N;
      for (int i = 0; i < N; i++) begin
         w_dist = (i + N - 1 - int'(i_ptr)) % N;
         if (i_req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_idx  = ID_W'(i);
            o_any  = 1'b1;
         end
      end
   end

endmodule : databus_rr_arbiter_rr_grant
`default_nettype wire

// File: rtl/databus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : databus_rr_arbiter
// Description : Shares one simple-AXI master (independent read and write
//               channels) between N_SLAVES Versat IO databus requesters.
//               Each channel runs its own round-robin arbiter and locks the
//               grant for a whole burst; one idle cycle follows each burst.
// Ports       : clk, rst                  clock, async active-high reset
//               s_valid/s_ready/s_last    per-requester handshake
//               s_addr/s_wdata/s_wstrb/s_len  packed per-requester fields
//               s_rdata                   broadcast read data
//               m_w*                      write request channel
//               m_r*, m_rdata             read request channel
//               w_busy/w_gnt, r_busy/r_gnt  channel grant status
// Revision    : 1.0 - initial release
// ============================================================================
module databus_rr_arbiter
   import databus_rr_arbiter_pkg::*;
#(
   parameter int  N_SLAVES = 2,
   parameter int  ADDR_W   = 32,
   parameter int  DATA_W   = 32,
   localparam int ID_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic                         clk,
   input  logic                         rst,

   // requester side
   input  logic [N_SLAVES-1:0]          s_valid,
   output logic [N_SLAVES-1:0]          s_ready,
   output logic [N_SLAVES-1:0]          s_last,
   input  logic [N_SLAVES*ADDR_W-1:0]   s_addr,
   input  logic [N_SLAVES*DATA_W-1:0]   s_wdata,
   input  logic [N_SLAVES*STRB_W-1:0]   s_wstrb,
   input  logic [N_SLAVES*LEN_W-1:0]    s_len,
   output logic [DATA_W-1:0]            s_rdata,

   // master write channel
   output logic                         m_wvalid,
   input  logic                         m_wready,
   input  logic                         m_wlast,
   output logic [ADDR_W-1:0]            m_waddr,
   output logic [DATA_W-1:0]            m_wdata,
   output logic [STRB_W-1:0]            m_wstrb,
   output logic [LEN_W-1:0]             m_wlen,

   // master read channel
   output logic                         m_rvalid,
   input  logic                         m_rready,
   input  logic                         m_rlast,
   output logic [ADDR_W-1:0]            m_raddr,
   output logic [LEN_W-1:0]             m_rlen,
   input  logic [DATA_W-1:0]            m_rdata,

   // status
   output logic                         w_busy,
   output logic                         r_busy,
   output logic [ID_W-1:0]              w_gnt,
   output logic [ID_W-1:0]              r_gnt
);

   // Pointer starts at the last requester so requester 0 wins first.
   localparam logic [ID_W-1:0] C_PTR_RST = ID_W'(N_SLAVES - 1);

   // ------------------------------------------------------------------
   // Request class decode
   // ------------------------------------------------------------------
   logic [N_SLAVES-1:0] w_is_wr;
   logic [N_SLAVES-1:0] w_wcand;
   logic [N_SLAVES-1:0] w_rcand;

   generate
      for (genvar g = 0; g < N_SLAVES; g++) begin : g_class
         logic [STRB_MAX_W-1:0] w_strb_ext;
         always_comb begin
            w_strb_ext             = '0;
            w_strb_ext[STRB_W-1:0] = s_wstrb[g*STRB_W +: STRB_W];
         end
         assign w_is_wr[g] = is_write(w_strb_ext);
      end
   endgenerate

   assign w_wcand = s_valid &  w_is_wr;
   assign w_rcand = s_valid & ~w_is_wr;

   // ------------------------------------------------------------------
   // Winner selection, one arbiter per channel
   // ------------------------------------------------------------------
   logic [ID_W-1:0] r_wptr, r_rptr;
   logic [ID_W-1:0] w_wwin_idx, w_rwin_idx;
   logic            w_wwin_any, w_rwin_any;

   databus_rr_arbiter_rr_grant #(
      .N    (N_SLAVES),
      .ID_W (ID_W)
   ) u_wr_grant (
      .i_req (w_wcand),
      .i_ptr (r_wptr),
      .o_idx (w_wwin_idx),
      .o_any (w_wwin_any)
   );

   databus_rr_arbiter_rr_grant #(
      .N    (N_SLAVES),
      .ID_W (ID_W)
   ) u_rd_grant (
      .i_req (w_rcand),
      .i_ptr (r_rptr),
      .o_idx (w_rwin_idx),
      .o_any (w_rwin_any)
   );

   // ------------------------------------------------------------------
   // Write channel FSM
   // ------------------------------------------------------------------
   ch_state_t       r_wstate, w_wstate_nxt;
   logic [ID_W-1:0] r_wgnt, w_wgnt_nxt, w_wptr_nxt;
   logic            w_wburst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate <= ST_IDLE;
         r_wgnt   <= '0;
         r_wptr   <= C_PTR_RST;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_wgnt   <= w_wgnt_nxt;
         r_wptr   <= w_wptr_nxt;
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wgnt_nxt   = r_wgnt;
      w_wptr_nxt   = r_wptr;
      case (r_wstate)
         ST_IDLE: begin
            if (w_wwin_any) begin
               w_wgnt_nxt   = w_wwin_idx;
               w_wptr_nxt   = w_wwin_idx;
               w_wstate_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (m_wvalid && m_wready && m_wlast) begin
               w_wstate_nxt = ST_IDLE;
            end
         end
         default: w_wstate_nxt = ST_IDLE;
      endcase
   end

   assign w_wburst = (r_wstate == ST_BURST);

   // ------------------------------------------------------------------
   // Read channel FSM
   // ------------------------------------------------------------------
   ch_state_t       r_rstate, w_rstate_nxt;
   logic [ID_W-1:0] r_rgnt, w_rgnt_nxt, w_rptr_nxt;
   logic            w_rburst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= ST_IDLE;
         r_rgnt   <= '0;
         r_rptr   <= C_PTR_RST;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_rgnt   <= w_rgnt_nxt;
         r_rptr   <= w_rptr_nxt;
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rgnt_nxt   = r_rgnt;
      w_rptr_nxt   = r_rptr;
      case (r_rstate)
         ST_IDLE: begin
            if (w_rwin_any) begin
               w_rgnt_nxt   = w_rwin_idx;
               w_rptr_nxt   = w_rwin_idx;
               w_rstate_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (m_rvalid && m_rready && m_rlast) begin
               w_rstate_nxt = ST_IDLE;
            end
         end
         default: w_rstate_nxt = ST_IDLE;
      endcase
   end

   assign w_rburst = (r_rstate == ST_BURST);

   // ------------------------------------------------------------------
   // Request muxing and handshake return
   // ------------------------------------------------------------------
   // The granted requester's class is re-evaluated every cycle: if it
   // flips class mid-burst, this channel simply sees valid low and stalls.
   // s_ready/s_last are OR-combined so a requester holding both grants
   // (possible only across a class change) hears from either channel.
   always_comb begin
      m_wvalid = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      m_wlen   = '0;
      m_rvalid = 1'b0;
      m_raddr  = '0;
      m_rlen   = '0;
      s_ready  = '0;
      s_last   = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (w_wburst && (r_wgnt == ID_W'(i))) begin
            m_wvalid   = s_valid[i] & w_is_wr[i];
            m_waddr    = s_addr[i*ADDR_W +: ADDR_W];
            m_wdata    = s_wdata[i*DATA_W +: DATA_W];
            m_wstrb    = s_wstrb[i*STRB_W +: STRB_W];
            m_wlen     = s_len[i*LEN_W +: LEN_W];
            s_ready[i] = s_ready[i] | m_wready;
            s_last[i]  = s_last[i]  | m_wlast;
         end
         if (w_rburst && (r_rgnt == ID_W'(i))) begin
            m_rvalid   = s_valid[i] & ~w_is_wr[i];
            m_raddr    = s_addr[i*ADDR_W +: ADDR_W];
            m_rlen     = s_len[i*LEN_W +: LEN_W];
            s_ready[i] = s_ready[i] | m_rready;
            s_last[i]  = s_last[i]  | m_rlast;
         end
      end
   end

   assign s_rdata = m_rdata;

   assign w_busy = w_wburst;
   assign r_busy = w_rburst;
   assign w_gnt  = r_wgnt;
   assign r_gnt  = r_rgnt;

endmodule : databus_rr_arbiter
`default_nettype wire
